// File: rtl/i2c_codec_cfg_master_if.sv
// Interface between the software PIO side and the codec configuration I2C pins.
// The master modport belongs to the write engine; the slave modport to whoever drives it.
interface i2c_codec_cfg_master_if;
  logic        start;
  logic [23:0] tx_data;
  logic        i2c_sclk;
  logic        i2c_sdat_oe;
  logic        i2c_sdat_in;
  logic        busy;
  logic        end_flag;
  logic        ack_err;

  modport master (
    input  start, tx_data, i2c_sdat_in,
    output i2c_sclk, i2c_sdat_oe, busy, end_flag, ack_err
  );

  modport slave (
    output start, tx_data, i2c_sdat_in,
    input  i2c_sclk, i2c_sdat_oe, busy, end_flag, ack_err
  );
endinterface

// File: rtl/i2c_codec_cfg_master.sv
// Single-master I2C write engine: START, three bytes each followed by an ACK slot, STOP.
// SCL and SDA are registered and change only on divider ticks (four ticks per bit).
module i2c_codec_cfg_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic                          clk,
  input  logic                          reset_n,
  i2c_codec_cfg_master_if.master        bus
);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  state_t      state, state_nx;
  logic [1:0]  phase, phase_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [1:0]  byte_cnt, byte_cnt_nx;
  logic [23:0] shreg, shreg_nx;
  logic [15:0] div_cnt, div_cnt_nx;
  logic        end_flag, end_flag_nx;
  logic        ack_err, ack_err_nx;
  logic        sclk, sclk_nx;
  logic        sdat_oe, sdat_oe_nx;
  logic [1:0]  sda_sync;
  logic        tick;
  logic        accept;

  assign tick   = (div_cnt == 16'(CLK_DIV - 1));
  assign accept = bus.start && (state == IDLE);

  // NOTE: every flop here, the shift register included, gets an async reset so a
  // mid-transfer reset releases the bus at once and the engine restarts clean.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      shreg    <= '0;
      div_cnt  <= '0;
      end_flag <= 1'b0;
      ack_err  <= 1'b0;
      sclk     <= 1'b1;
      sdat_oe  <= 1'b0;
      sda_sync <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state    <= state_nx;
      phase    <= phase_nx;
      bit_cnt  <= bit_cnt_nx;
      byte_cnt <= byte_cnt_nx;
      shreg    <= shreg_nx;
      div_cnt  <= div_cnt_nx;
      end_flag <= end_flag_nx;
      ack_err  <= ack_err_nx;
      sclk     <= sclk_nx;
      sdat_oe  <= sdat_oe_nx;
      sda_sync <= {sda_sync[0], bus.i2c_sdat_in};
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_nx    = state;
    phase_nx    = phase;
    bit_cnt_nx  = bit_cnt;
    byte_cnt_nx = byte_cnt;
    shreg_nx    = shreg;
    end_flag_nx = end_flag;
    ack_err_nx  = ack_err;
    div_cnt_nx  = (state == IDLE || tick) ? '0 : div_cnt + 16'd1;
    case (state)
      IDLE: if (accept) begin
        state_nx    = START;
        phase_nx    = '0;
        bit_cnt_nx  = 3'd7;
        byte_cnt_nx = '0;
        shreg_nx    = bus.tx_data;
        end_flag_nx = 1'b0;
        ack_err_nx  = 1'b0;
      end
      START: if (tick) begin
        if (phase == 2'd0) phase_nx = 2'd1;
        else begin
          state_nx = BIT;
          phase_nx = '0;
        end
      end
      BIT: if (tick) begin
        phase_nx = phase + 2'd1;
        if (phase == 2'd3) begin
          shreg_nx = {shreg[22:0], 1'b0};
          if (bit_cnt == 3'd0) state_nx = ACK;
          else bit_cnt_nx = bit_cnt - 3'd1;
        end
      end
      ACK: if (tick) begin
        phase_nx = phase + 2'd1;
        // Sample at the end of the second SCL-high quarter, well inside the high time
        if (phase == 2'd2 && sda_sync[1]) ack_err_nx = 1'b1;
        if (phase == 2'd3) begin
          if (ack_err || byte_cnt == 2'd2) state_nx = STOP;
          else begin
            state_nx    = BIT;
            byte_cnt_nx = byte_cnt + 2'd1;
            bit_cnt_nx  = 3'd7;
          end
        end
      end
      STOP: if (tick) begin
        if (phase == 2'd2) begin
          state_nx    = IDLE;
          phase_nx    = '0;
          end_flag_nx = 1'b1;
        end else phase_nx = phase + 2'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin levels decoded from the next state, so they are registered alongside it
  always_comb begin
    sclk_nx    = 1'b1;
    sdat_oe_nx = 1'b0;
    case (state_nx)
      START: begin
        sclk_nx    = (phase_nx == 2'd0);
        sdat_oe_nx = 1'b1;
      end
      BIT: begin
        sclk_nx    = phase_nx[1] ^ phase_nx[0];
        sdat_oe_nx = ~shreg_nx[23];
      end
      ACK: begin
        sclk_nx    = phase_nx[1] ^ phase_nx[0];
        sdat_oe_nx = 1'b0;
      end
      STOP: begin
        sclk_nx    = (phase_nx != 2'd0);
        sdat_oe_nx = (phase_nx != 2'd2);
      end
      default: begin
        sclk_nx    = 1'b1;
        sdat_oe_nx = 1'b0;
      end
    endcase
  end

  assign bus.i2c_sclk    = sclk;
  assign bus.i2c_sdat_oe = sdat_oe;
  assign bus.busy        = (state != IDLE);
  assign bus.end_flag    = end_flag;
  assign bus.ack_err     = ack_err;

endmodule

// File: tb/tb_i2c_codec_cfg_master.sv
// Bench for i2c_codec_cfg_master: bus decoder + ACK slave + completion monitor,
// checked against a transaction-level model of the expected bus events and timing.
module tb_i2c_codec_cfg_master;
  localparam int DIV      = 4;
  localparam int EV_START = 256;
  localparam int EV_STOP  = 512;
  localparam int EV_ACK   = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic slave_pull = 1'b0;
  logic mon_en = 1'b0;
  int   nack_byte = 3;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  typedef struct {
    int   fall;
    logic err;
  } done_t;

  int    exp_bus[$];
  done_t exp_done[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_codec_cfg_master_if bus ();
  assign bus.i2c_sdat_in = ~(bus.i2c_sdat_oe | slave_pull);

  i2c_codec_cfg_master #(.CLK_DIV(DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic fail_now(input string name, input string got, input string exp);
    n_checks++;
    $display("FAIL %s: got %s expected %s (t=%0t)", name, got, exp, $time);
  endtask

  // Model: bytes clocked until the first NACK (or all three), then STOP; 4 ticks/bit, 9 bits/byte
  function automatic int model_push(input logic [23:0] d, input int nack, input int accept_edge);
    int    n;
    done_t e;
    n = (nack < 3) ? nack + 1 : 3;
    exp_bus.push_back(EV_START);
    for (int i = 0; i < n; i++) begin
      exp_bus.push_back(int'(d[23 - 8*i -: 8]));
      exp_bus.push_back(EV_ACK | int'(i == nack));
    end
    exp_bus.push_back(EV_STOP);
    e.fall = accept_edge + (2 + 36*n + 3) * DIV;
    e.err  = (nack < 3);
    exp_done.push_back(e);
    return e.fall;
  endfunction

  task automatic bus_event(input int ev);
    if (exp_bus.size() == 0) begin
      n_checks++;
      $display("FAIL bus_event: got 0x%0h expected none", ev);
    end else check("bus_event", ev, exp_bus.pop_front());
  endtask

  // Bus decoder, protocol timing and ACKing slave, all sampled on the falling clock edge
  initial begin
    logic       scl, sda, scl_p, sda_p;
    logic [7:0] sh;
    int         rise_cnt, last_edge, pos, b;
    bit         edge_ok;
    scl_p = 1'b1; sda_p = 1'b1; sh = '0;
    rise_cnt = 0; last_edge = 0; edge_ok = 0;
    forever begin
      @(negedge clk);
      scl = bus.i2c_sclk;
      sda = bus.i2c_sdat_in;
      if (!reset_n || !mon_en) begin
        rise_cnt   = 0;
        edge_ok    = 0;
        slave_pull = 1'b0;
      end else begin
        if (scl && scl_p && sda != sda_p) begin
          bus_event(sda ? EV_STOP : EV_START);
          if (!sda) begin
            rise_cnt = 0;
            edge_ok  = 0;
          end
        end
        if (scl != scl_p) begin
          if (edge_ok) check(scl ? "scl_low_time" : "scl_high_time", cyc - last_edge, 2*DIV);
          edge_ok   = 1;
          last_edge = cyc;
          if (scl) begin
            rise_cnt++;
            pos = (rise_cnt - 1) % 9;
            if (pos < 8) sh = {sh[6:0], sda};
            if (pos == 7) bus_event(int'(sh));
            if (pos == 8) bus_event(EV_ACK | int'(sda));
          end
        end
        b = (rise_cnt + 1) / 9 - 1;
        slave_pull = ((!scl && rise_cnt % 9 == 8) || (scl && rise_cnt % 9 == 0 && rise_cnt > 0))
                     && (b < nack_byte);
      end
      scl_p = scl;
      sda_p = sda;
    end
  end

  // Completion monitor
  initial begin
    logic  busy_p;
    done_t e;
    busy_p = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && busy_p && !bus.busy) begin
        if (exp_done.size() == 0) fail_now("done_event", "completion", "none");
        else begin
          e = exp_done.pop_front();
          check("done_cycle", cyc, e.fall);
          check("end_flag_set", bus.end_flag, 1'b1);
          check("ack_err_final", bus.ack_err, e.err);
        end
      end
      busy_p = bus.busy;
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
    end
    fail_now("wait_idle", "busy", "idle within 2000 cycles");
  endtask

  task automatic launch(input logic [23:0] d, input int nack);
    int f;
    @(negedge clk);
    nack_byte   = nack;
    bus.tx_data = d;
    bus.start   = 1'b1;
    f = model_push(d, nack, cyc + 1);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.tx_data = 24'($urandom());
    check("busy_after_start", bus.busy, 1'b1);
    check("end_flag_cleared", bus.end_flag, 1'b0);
    check("ack_err_cleared", bus.ack_err, 1'b0);
  endtask

  initial begin
    int f1;
    logic [23:0] d2;
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1;
    logic [23:0] d1, d2;
    bus.start   = 1'b0;
    bus.tx_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", bus.i2c_sclk, 1'b1);
    check("rst_sdat_oe", bus.i2c_sdat_oe, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_end_flag", bus.end_flag, 1'b0);
    check("rst_ack_err", bus.ack_err, 1'b0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk);

    launch(24'h34_1E_00, 3); wait_idle();
    launch(24'h36_12_34, 0); wait_idle();
    repeat (10) @(negedge clk);
    check("ack_err_sticky", bus.ack_err, 1'b1);
    check("end_flag_sticky", bus.end_flag, 1'b1);
    launch(24'h34_1E_00, 1); wait_idle();

    // Second start while busy must be ignored
    launch(24'h34_1E_00, 3);
    repeat (99) @(negedge clk);
    bus.tx_data = 24'hA5_5A_C3;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    wait_idle();
    @(negedge clk);
    check("end_flag_before_restart", bus.end_flag, 1'b1);
    launch(24'h5A_01_FF, 2); wait_idle();

    // Start held high: restart one cycle after completion, new data latched then
    d1 = 24'hC3_3C_81;
    d2 = 24'h18_E7_42;
    @(negedge clk);
    nack_byte   = 3;
    bus.tx_data = d1;
    bus.start   = 1'b1;
    f1 = model_push(d1, 3, cyc + 1);
    void'(model_push(d2, 3, f1 + 1));
    @(negedge clk);
    bus.tx_data = d2;
    while (cyc < f1 + 1) @(negedge clk);
    bus.start = 1'b0;
    check("held_restart_busy", bus.busy, 1'b1);
    wait_idle();

    for (int i = 0; i < 10; i++) begin
      launch(24'($urandom()), int'($urandom_range(0, 3)));
      wait_idle();
    end

    // Reset at tick 50 of a transfer releases the bus in the same cycle
    launch(24'h34_1E_00, 3);
    mon_en = 1'b0;
    repeat (200) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_sclk", bus.i2c_sclk, 1'b1);
    check("midrst_sdat_oe", bus.i2c_sdat_oe, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_end_flag", bus.end_flag, 1'b0);
    check("midrst_ack_err", bus.ack_err, 1'b0);
    exp_bus.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    launch(24'h34_55_AA, 3); wait_idle();

    repeat (4) @(negedge clk);
    check("bus_queue_drained", exp_bus.size(), 0);
    check("done_queue_drained", exp_done.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
